// File: rtl/fpdiv_post_s32_pkg.sv
// Shared fp32 divide/sqrt definitions: sideband class encodings, fp32 constants,
// exception flag bit positions, field widths and the default divider latency.
package fpdiv_post_s32_pkg;

  localparam int unsigned DIV_LAT_DEF = 7;
  localparam int unsigned QUOT_W      = 48;
  localparam int unsigned REM_W       = 23;
  localparam int unsigned EXP_W       = 10;
  localparam int unsigned EXPN_W      = 11;
  localparam int unsigned CLS_W       = 3;
  localparam int unsigned MANT_W      = 23;
  localparam int unsigned FP_W        = 32;
  localparam int unsigned FLAG_W      = 5;

  typedef enum logic [CLS_W-1:0] {
    CLS_NORM    = 3'd0,
    CLS_ZERO    = 3'd1,
    CLS_INF     = 3'd2,
    CLS_QNAN    = 3'd3,
    CLS_DIVZ    = 3'd4,
    CLS_INVALID = 3'd5
  } cls_e;

  localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [7:0]      FP_EXP_MAX = 8'hFE;
  localparam logic [7:0]      FP_EXP_INF = 8'hFF;

  // flags = {invalid, divzero, overflow, underflow, inexact}
  localparam int unsigned FLG_NX  = 0;
  localparam int unsigned FLG_UF  = 1;
  localparam int unsigned FLG_OF  = 2;
  localparam int unsigned FLG_DZ  = 3;
  localparam int unsigned FLG_INV = 4;

  typedef struct packed {
    logic                    sign;
    logic signed [EXP_W-1:0] exp;
    logic [CLS_W-1:0]        cls;
  } sb_t;

endpackage

// File: rtl/fpdiv_post_s32_if.sv
// Bus between the divider/issue logic and the divide post-processing stage.
// master: drives en, divider output and issue-time sideband; slave: the stage.
interface fpdiv_post_s32_if;
  import fpdiv_post_s32_pkg::*;

  logic                    en;
  logic                    vldin;
  logic [QUOT_W-1:0]       quot;
  logic [REM_W-1:0]        rem;
  logic                    sb_vld;
  logic                    sb_sign;
  logic signed [EXP_W-1:0] sb_exp;
  logic [CLS_W-1:0]        sb_class;
  logic                    vldout;
  logic [FP_W-1:0]         result;
  logic [FLAG_W-1:0]       flags;
  logic                    align_err;

  modport master (
    output en, vldin, quot, rem, sb_vld, sb_sign, sb_exp, sb_class,
    input  vldout, result, flags, align_err
  );

  modport slave (
    input  en, vldin, quot, rem, sb_vld, sb_sign, sb_exp, sb_class,
    output vldout, result, flags, align_err
  );

endinterface

// File: rtl/fpdiv_sb_delay.sv
// Enabled shift register carrying operand sideband alongside an iterative datapath.
// Ports: clk, rst_n (sync, active-low), en (advance), in_vld/in_data (entry),
//        out_vld/out_data (entry inserted DEPTH enabled cycles earlier).
// Only valid bits are reset; data bits are don't-care while invalid.
module fpdiv_sb_delay #(
  parameter int unsigned DEPTH = 7,
  parameter int unsigned W     = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];

  // Next-state: shift one place toward the output.
  always_comb begin
    vld_d     = vld_q;
    data_d    = data_q;
    vld_d[0]  = in_vld;
    data_d[0] = in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      data_q <= data_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/fpdiv_post_s32.sv
// fp32 divide post-processing: pairs divider quotient/remainder with delayed
// operand sideband, normalises, truncates, resolves special cases and packs.
// Ports: clk, rst_n (sync, active-low), bus (slave): en, vldin, quot, rem,
//        sb_* in; vldout, result, flags, align_err (sticky) out.
module fpdiv_post_s32
  import fpdiv_post_s32_pkg::*;
#(
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input logic              clk,
  input logic              rst_n,
  fpdiv_post_s32_if.slave  bus
);

  sb_t  sb_in, sb_dly;
  logic dly_vld;
  logic quot_unused;

  assign sb_in       = {bus.sb_sign, bus.sb_exp, bus.sb_class};
  assign quot_unused = ^bus.quot[QUOT_W-1:26];

  fpdiv_sb_delay #(
    .DEPTH (DIV_LAT),
    .W     ($bits(sb_t))
  ) u_sb_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .in_vld   (bus.sb_vld),
    .in_data  (sb_in),
    .out_vld  (dly_vld),
    .out_data (sb_dly)
  );

  logic                     a_vld_q, a_vld_d;
  logic                     a_sign_q, a_sign_d;
  logic [CLS_W-1:0]         a_cls_q, a_cls_d;
  logic signed [EXPN_W-1:0] a_exp_q, a_exp_d;
  logic [MANT_W-1:0]        a_mant_q, a_mant_d;
  logic                     a_inexact_q, a_inexact_d;
  logic                     vldout_q, vldout_d;
  logic [FP_W-1:0]          result_q, result_d;
  logic [FLAG_W-1:0]        flags_q, flags_d;
  logic                     align_err_q, align_err_d;

  // Stage A: normalise q = quot[25:0] in (2^23, 2^25] to 1.m, truncating.
  always_comb begin
    logic signed [EXPN_W-1:0] exp_x;
    logic [25:0]              q;
    q           = bus.quot[25:0];
    exp_x       = {sb_dly.exp[EXP_W-1], sb_dly.exp};
    a_vld_d     = bus.vldin & dly_vld;
    a_sign_d    = sb_dly.sign;
    a_cls_d     = sb_dly.cls;
    a_exp_d     = exp_x - 11'sd1;
    a_mant_d    = q[22:0];
    a_inexact_d = |bus.rem;
    if (q[25]) begin
      a_exp_d     = exp_x + 11'sd1;
      a_mant_d    = '0;
      a_inexact_d = 1'b0;
    end else if (q[24]) begin
      a_exp_d     = exp_x;
      a_mant_d    = q[23:1];
      a_inexact_d = q[0] | (|bus.rem);
    end
    // A divider/sideband disagreement is remembered until reset.
    align_err_d = align_err_q | (bus.vldin ^ dly_vld);
  end

  // Stage B: classify and pack; result/flags hold while no new result.
  always_comb begin
    vldout_d = a_vld_q;
    result_d = result_q;
    flags_d  = flags_q;
    if (a_vld_q) begin
      flags_d = '0;
      case (a_cls_q)
        CLS_NORM: begin
          if (a_exp_q >= 11'sd255) begin
            result_d        = {a_sign_q, FP_EXP_MAX, {MANT_W{1'b1}}};
            flags_d[FLG_OF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
          end else if (a_exp_q <= 11'sd0) begin
            result_d        = {a_sign_q, 31'd0};
            flags_d[FLG_UF] = 1'b1;
            flags_d[FLG_NX] = 1'b1;
          end else begin
            result_d        = {a_sign_q, a_exp_q[7:0], a_mant_q};
            flags_d[FLG_NX] = a_inexact_q;
          end
        end
        CLS_ZERO: result_d = {a_sign_q, 31'd0};
        CLS_INF:  result_d = {a_sign_q, FP_EXP_INF, {MANT_W{1'b0}}};
        CLS_QNAN: result_d = FP_QNAN;
        CLS_DIVZ: begin
          result_d        = {a_sign_q, FP_EXP_INF, {MANT_W{1'b0}}};
          flags_d[FLG_DZ] = 1'b1;
        end
        default: begin
          result_d         = FP_QNAN;
          flags_d[FLG_INV] = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_vld_q     <= 1'b0;
      vldout_q    <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      align_err_q <= 1'b0;
    end else if (bus.en) begin
      a_vld_q     <= a_vld_d;
      vldout_q    <= vldout_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      align_err_q <= align_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.en) begin
      a_sign_q    <= a_sign_d;
      a_cls_q     <= a_cls_d;
      a_exp_q     <= a_exp_d;
      a_mant_q    <= a_mant_d;
      a_inexact_q <= a_inexact_d;
    end
  end

  assign bus.vldout    = vldout_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.align_err = align_err_q;

endmodule

// File: tb/tb_fpdiv_post_s32.sv
// Directed bench for fpdiv_post_s32: stands in for the 7-stage divider, feeds
// hand-computed vectors and checks result, flags, latency and sticky error.
module tb_fpdiv_post_s32;
  import fpdiv_post_s32_pkg::*;

  localparam int unsigned LAT = DIV_LAT_DEF;

  logic clk;
  logic rst_n;
  fpdiv_post_s32_if bus ();

  fpdiv_post_s32 #(.DIV_LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          sv;
    bit          dv;
    bit          sg;
    logic [9:0]  ex;
    logic [2:0]  cl;
    logic [47:0] qt;
    logic [22:0] rm;
    logic [31:0] er;
    logic [4:0]  ef;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  flg;
    int          cnt;
  } exp_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   ecnt  = 0;
  bit   en_s  = 1'b0;
  exp_t expq[$];

  logic        dv_vld  [LAT];
  logic [47:0] dv_quot [LAT];
  logic [22:0] dv_rem  [LAT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  function automatic op_t idle_op();
    op_t o;
    o.sv = 1'b0; o.dv = 1'b0; o.sg = 1'b0; o.ex = '0; o.cl = '0;
    o.qt = '0;   o.rm = '0;   o.er = '0;   o.ef = '0;
    return o;
  endfunction

  function automatic op_t mk(input bit sg, input logic [9:0] ex, input logic [2:0] cl,
                             input logic [47:0] qt, input logic [22:0] rm,
                             input logic [31:0] er, input logic [4:0] ef);
    op_t o;
    o.sv = 1'b1; o.dv = 1'b1; o.sg = sg; o.ex = ex; o.cl = cl;
    o.qt = qt;   o.rm = rm;   o.er = er; o.ef = ef;
    return o;
  endfunction

  function automatic void clear_div();
    for (int i = 0; i < int'(LAT); i++) begin
      dv_vld[i] = 1'b0; dv_quot[i] = '0; dv_rem[i] = '0;
    end
  endfunction

  // One clock: present sideband now, divider output from the model's head.
  task automatic tick(input bit e, input op_t o);
    bus.en       = e;
    bus.sb_vld   = o.sv;
    bus.sb_sign  = o.sg;
    bus.sb_exp   = o.ex;
    bus.sb_class = o.cl;
    bus.vldin    = dv_vld[LAT-1];
    bus.quot     = dv_quot[LAT-1];
    bus.rem      = dv_rem[LAT-1];
    if (e && o.sv && o.dv && rst_n) begin
      exp_t x;
      x.res = o.er; x.flg = o.ef; x.cnt = ecnt;
      expq.push_back(x);
    end
    @(posedge clk);
    if (e) begin
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        dv_vld[i] = dv_vld[i-1]; dv_quot[i] = dv_quot[i-1]; dv_rem[i] = dv_rem[i-1];
      end
      dv_vld[0] = o.dv; dv_quot[0] = o.qt; dv_rem[0] = o.rm;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, idle_op());
  endtask

  always @(posedge clk) begin
    en_s <= bus.en & rst_n;
    if (bus.en) ecnt <= ecnt + 1;
  end

  // New result appears after every enabled edge with vldout set.
  always @(negedge clk) begin
    if (en_s && bus.vldout) begin
      n_out++;
      if (expq.size() == 0) begin
        check("spurious_vldout", 32'd1, 32'd0);
      end else begin
        exp_t x;
        x = expq.pop_front();
        check("result", bus.result, x.res);
        check("flags", 32'(bus.flags), 32'(x.flg));
        check("latency", 32'(ecnt - x.cnt), 32'(LAT + 2));
      end
    end
  end

  op_t vec[$];

  initial begin
    int n_before;
    bus.en = 1'b0; bus.vldin = 1'b0; bus.quot = '0; bus.rem = '0;
    bus.sb_vld = 1'b0; bus.sb_sign = 1'b0; bus.sb_exp = '0; bus.sb_class = '0;
    clear_div();
    rst_n = 1'b0;
    #2;
    idle(2);
    check("rst_vldout", 32'(bus.vldout), 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_align", 32'(bus.align_err), 32'd0);
    rst_n = 1'b1;

    // Directed vectors: sign, sb_exp, class, quot, rem -> result, flags.
    vec.push_back(mk(0, 10'd127, 3'd0, 48'h1800000, 23'd0, 32'h3FC00000, 5'h00));
    vec.push_back(mk(0, 10'd126, 3'd0, 48'hAAAAAB,  23'd0, 32'h3EAAAAAB, 5'h00));
    vec.push_back(mk(0, 10'd126, 3'd0, 48'hAAAAAB,  23'd5, 32'h3EAAAAAB, 5'h01));
    vec.push_back(mk(1, 10'd300, 3'd0, 48'h1800000, 23'd0, 32'hFF7FFFFF, 5'h05));
    vec.push_back(mk(1, 10'h3FB, 3'd0, 48'h1800000, 23'd0, 32'h80000000, 5'h03));
    vec.push_back(mk(1, 10'd300, 3'd4, 48'h1800001, 23'd3, 32'hFF800000, 5'h08));
    vec.push_back(mk(1, 10'h3FB, 3'd5, 48'h1800001, 23'd3, 32'h7FC00000, 5'h10));
    vec.push_back(mk(1, 10'd127, 3'd1, 48'h1800001, 23'd3, 32'h80000000, 5'h00));
    vec.push_back(mk(1, 10'd127, 3'd3, 48'h1800001, 23'd3, 32'h7FC00000, 5'h00));
    vec.push_back(mk(1, 10'd127, 3'd2, 48'h1800001, 23'd3, 32'hFF800000, 5'h00));
    vec.push_back(mk(0, 10'd127, 3'd6, 48'h1800000, 23'd0, 32'h7FC00000, 5'h10));
    vec.push_back(mk(0, 10'd127, 3'd0, 48'hABCD02000000, 23'd0, 32'h40000000, 5'h00));
    vec.push_back(mk(0, 10'd127, 3'd0, 48'h1800001, 23'd0, 32'h3FC00000, 5'h01));
    vec.push_back(mk(0, 10'd254, 3'd0, 48'h1800000, 23'd0, 32'h7F400000, 5'h00));
    vec.push_back(mk(0, 10'd254, 3'd0, 48'h2000000, 23'd0, 32'h7F7FFFFF, 5'h05));
    vec.push_back(mk(0, 10'd1,   3'd0, 48'hAAAAAB,  23'd0, 32'h00000000, 5'h03));
    vec.push_back(mk(0, 10'd1,   3'd0, 48'h1800000, 23'd0, 32'h00C00000, 5'h00));
    foreach (vec[i]) tick(1'b1, vec[i]);
    idle(12);
    check("drained_directed", 32'(expq.size()), 32'd0);
    check("hold_result", bus.result, 32'h00C00000);
    check("hold_vldout", 32'(bus.vldout), 32'd0);

    // Stream of 20 with en toggling: mant = i<<3, exponent 100+i.
    for (int i = 0; i < 20; i++) begin
      op_t o;
      bit  e;
      int  tries;
      logic [7:0]  ebits;
      logic [22:0] mbits;
      ebits = 8'(100 + i);
      mbits = 23'(i * 8);
      o = mk(i[0], 10'(100 + i), 3'd0, 48'(32'h1000000 | (i * 16)), 23'd0,
             {i[0], ebits, mbits}, 5'h00);
      tries = 0;
      do begin
        e = ($urandom_range(0, 1) == 1) || (tries > 4);
        tick(e, o);
        tries++;
      end while (!e);
    end
    for (int i = 0; i < 30; i++) tick($urandom_range(0, 1) == 1, idle_op());
    idle(12);
    check("drained_stream", 32'(expq.size()), 32'd0);
    check("stream_align", 32'(bus.align_err), 32'd0);

    // Reset with 5 in flight: none of them may emerge.
    for (int i = 0; i < 5; i++)
      tick(1'b1, mk(0, 10'd127, 3'd0, 48'h1800000, 23'd0, 32'h3FC00000, 5'h00));
    n_before = n_out;
    rst_n = 1'b0;
    tick(1'b1, idle_op());
    rst_n = 1'b1;
    expq.delete();
    clear_div();
    check("rst2_vldout", 32'(bus.vldout), 32'd0);
    check("rst2_result", bus.result, 32'd0);
    check("rst2_flags", 32'(bus.flags), 32'd0);
    idle(15);
    check("rst2_no_outputs", 32'(n_out - n_before), 32'd0);
    tick(1'b1, mk(0, 10'd126, 3'd0, 48'hAAAAAB, 23'd0, 32'h3EAAAAAB, 5'h00));
    idle(12);
    check("rst2_post_out", 32'(n_out - n_before), 32'd1);

    // Divider valid without matching sideband: sticky align_err.
    begin
      op_t o;
      o = idle_op();
      o.dv = 1'b1;
      o.qt = 48'h1800000;
      tick(1'b1, o);
    end
    idle(int'(LAT) - 1);
    check("align_before", 32'(bus.align_err), 32'd0);
    idle(1);
    check("align_set", 32'(bus.align_err), 32'd1);
    idle(10);
    check("align_sticky", 32'(bus.align_err), 32'd1);
    rst_n = 1'b0;
    tick(1'b1, idle_op());
    rst_n = 1'b1;
    check("align_cleared", 32'(bus.align_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
